esp_req_sched: RTL and testbench
================================

Name: esp_req_sched

Overview:
- Sequences all transactions to the ESP co-processor over the ESP_REQ / ESP_S / ESP_DONE handshake.
- Arbitrates between two requesters:
  - Z80 bus I/O requests: TRS-IO, FreHD and printer port selects.
  - Internal XRAY debugger requests.
- Drives the Z80 WAIT line for bus requests and releases it on ESP completion or on a watchdog timeout.
- Sits between the address decoder (esp_sel / ESP_S code generation) and the ESP pins in the top level, replacing the inline count/WAIT logic.

Parameters:
- REQ_PULSE, 50: esp_req high time in clk cycles (84 MHz); legal range 1..255.
- TIMEOUT, 1048576: clk cycles spent in WAIT_DONE before forced release (about 12.5 ms); legal range 2..2^24-1.
- CNT_W, 24: width of the shared pulse/timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, 84 MHz.
- srst  in  1  synchronous active-high reset.
- bus_req  in  1  one-cycle pulse: Z80 access to an ESP-served port (esp_sel && io_access).
- bus_code  in  3  ESP_S code for bus_req; sampled only in the bus_req cycle.
- xray_req  in  1  level: XRAY service pending; held until xray_ack.
- xray_ack  out  1  one-cycle pulse on XRAY transaction completion or timeout.
- esp_done  in  1  raw asynchronous ESP_DONE pin.
- esp_req  out  1  ESP_REQ pin.
- esp_s  out  3  ESP_S pin; transaction code.
- wait_o  out  1  Z80 WAIT, active high.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky: a transaction timed out.
- overrun_err  out  1  sticky: a bus_req arrived while busy.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, done synchroniser flops 0. srst in any state aborts the transaction with no ack and no error flag.
- Done detection:
  - esp_done passes through a 2-flop synchroniser plus an edge register.
  - done_rise is high for one cycle on 0->1 of the synchronised signal, 3 cycles after the pin edge.
- IDLE:
  - bus_req=1 -> latch code=bus_code, src=BUS, go REQ, counter=REQ_PULSE-1.
  - Else xray_req=1 -> code=3'd6 (ESP_XRAY), src=XRAY, go REQ, counter=REQ_PULSE-1.
  - Both in the same cycle: bus wins; xray stays pending and is serviced next (fairness not required).
- REQ:
  - esp_req=1 and esp_s=code, from the first REQ cycle.
  - wait_o=1 if src=BUS, else 0.
  - When counter==0, go WAIT_DONE with counter=0; otherwise decrement. esp_req is therefore high for exactly REQ_PULSE cycles.
  - done_rise during REQ sets done_seen.
- WAIT_DONE:
  - esp_req=0; esp_s holds code; wait_o holds.
  - done_rise or done_seen -> go IDLE next edge. wait_o=0 in the IDLE cycle; xray_ack pulses if src=XRAY.
  - counter==TIMEOUT-1 without done -> go IDLE, set timeout_err, release wait_o; xray_ack pulses if src=XRAY.
  - Otherwise increment counter.
- Latency: bus_req edge -> esp_req/wait_o high at the next clk edge, i.e. 1 cycle.
- esp_s is 0 in IDLE.
- bus_req while busy: dropped and overrun_err set. No effect on the current transaction.
- err_clr has priority over a same-cycle set: the flag ends at 0; the error is lost, which is acceptable.
- done_rise in IDLE: ignored, and done_seen is cleared on REQ entry.
- Back-to-back transactions: a new request is accepted in the first IDLE cycle after completion, giving a minimum of 1 idle cycle between transactions.

Decomposition:
- Package esp_pkg:
  - ESP_S code localparams: TRS_IO_IN=0, TRS_IO_OUT=1, FREHD_IN=2, FREHD_OUT=3, PRN_RD=4, PRN_WR=5, XRAY=6.
  - State encoding: IDLE, REQ, WAIT_DONE.
  - src enum: BUS, XRAY.
- Sub-module sync_rise: 2-flop synchroniser plus rising-edge detect, reset to 0; reusable for SCK and CS later.

Test Plan:
- Bus transaction: srst, then bus_req with bus_code=2 -> next cycle esp_req=1, esp_s=2, wait_o=1. esp_req high for exactly 50 cycles. Raise esp_done at cycle 200 -> wait_o=0 four cycles later; esp_s=0; busy=0; no xray_ack.
- XRAY transaction: xray_req held -> esp_s=6 and wait_o=0 throughout. esp_done pulse -> single xray_ack pulse, then requester drops xray_req -> no second transaction.
- Early done and simultaneous requests:
  - esp_done rises during the REQ pulse -> esp_req still lasts 50 cycles, then immediate return to IDLE (done_seen path).
  - bus_req and xray_req in the same cycle -> bus served first (esp_s=bus_code, wait_o=1), then XRAY starts on the first IDLE cycle.
- Timeout: TIMEOUT=1000, no esp_done -> wait_o drops 1000 cycles after entering WAIT_DONE; timeout_err=1 and stays set. err_clr -> 0.
- Overrun: bus_req in WAIT_DONE -> overrun_err=1, esp_s unchanged, transaction completes normally on done.
- Reset mid-operation: srst in WAIT_DONE with wait_o=1 -> next cycle all outputs 0, no ack, flags 0. A subsequent bus_req behaves as in the bus-transaction case.

Source files
------------

// File: rtl/esp_pkg.sv
// esp_pkg: shared definitions for the ESP request scheduler.
//   - ESP_S transaction codes driven on the ESP_S pins
//   - scheduler state encoding (plain constants for legacy tools)
//   - requester source type
package esp_pkg;

  typedef logic [2:0] esp_code_t;

  localparam esp_code_t ESP_TRS_IO_IN  = 3'd0;
  localparam esp_code_t ESP_TRS_IO_OUT = 3'd1;
  localparam esp_code_t ESP_FREHD_IN   = 3'd2;
  localparam esp_code_t ESP_FREHD_OUT  = 3'd3;
  localparam esp_code_t ESP_PRN_RD     = 3'd4;
  localparam esp_code_t ESP_PRN_WR     = 3'd5;
  localparam esp_code_t ESP_XRAY       = 3'd6;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  typedef enum logic {
    SRC_BUS  = 1'b0,
    SRC_XRAY = 1'b1
  } src_e;

endpackage

// File: rtl/esp_req_sched_if.sv
// esp_req_sched_if: requester and ESP pin signals of the ESP request scheduler.
//   bus_req/bus_code : Z80 I/O request pulse and its ESP_S code
//   wait_o           : Z80 WAIT, active high
//   xray_req/ack     : XRAY debugger request level and completion pulse
//   esp_req/esp_s    : ESP_REQ and ESP_S pins
//   esp_done         : raw asynchronous ESP_DONE pin
// Modport slave is the scheduler side; master is the surrounding system.
interface esp_req_sched_if;
  import esp_pkg::*;

  logic      bus_req;
  esp_code_t bus_code;
  logic      wait_o;
  logic      xray_req;
  logic      xray_ack;
  logic      esp_req;
  esp_code_t esp_s;
  logic      esp_done;

  modport slave (
    input  bus_req, bus_code, xray_req, esp_done,
    output wait_o, xray_ack, esp_req, esp_s
  );

  modport master (
    output bus_req, bus_code, xray_req, esp_done,
    input  wait_o, xray_ack, esp_req, esp_s
  );

endinterface

// File: rtl/sync_rise.sv
// sync_rise: two-flop synchroniser for an asynchronous input followed by a
// registered rising-edge detector.
//   clk  : sampling clock
//   srst : synchronous active-high reset, clears all flops
//   d    : asynchronous input
//   rise : one-cycle pulse, high 3 cycles after d first samples high
module sync_rise (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic rise
);

  // sh[0], sh[1] form the synchroniser; sh[2] is the previous synchronised level.
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (srst) begin
      sh   <= '0;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], d};
      rise <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/esp_req_sched.sv
// esp_req_sched: sequences every transaction to the ESP co-processor.
// Arbitrates Z80 bus requests (priority) against XRAY debugger requests,
// pulses ESP_REQ for REQ_PULSE cycles, then waits for ESP_DONE or a
// TIMEOUT-cycle watchdog. Holds Z80 WAIT for bus transactions.
//   clk, srst   : clock and synchronous active-high reset
//   esp         : requester / ESP pin interface (slave side)
//   busy        : high whenever a transaction is in progress
//   timeout_err : sticky, a transaction was released by the watchdog
//   overrun_err : sticky, a bus request arrived while busy and was dropped
//   err_clr     : clears both sticky flags, wins over a same-cycle set
module esp_req_sched
  import esp_pkg::*;
#(
  parameter int REQ_PULSE = 50,
  parameter int TIMEOUT   = 1048576,
  parameter int CNT_W     = 24
) (
  input  logic             clk,
  input  logic             srst,
  esp_req_sched_if.slave   esp,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] REQ_LOAD = CNT_W'(REQ_PULSE - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  esp_code_t        code;
  src_e             src;
  logic             done_seen;
  logic             done_rise;
  logic             xray_ack_q;
  logic             done_hit;
  logic             timeout_hit;
  logic             overrun_hit;

  sync_rise u_done_sync (
    .clk  (clk),
    .srst (srst),
    .d    (esp.esp_done),
    .rise (done_rise)
  );

  assign done_hit    = (state == ST_WAIT_DONE) && (done_rise || done_seen);
  assign timeout_hit = (state == ST_WAIT_DONE) && !(done_rise || done_seen) && (cnt == TO_LAST);
  assign overrun_hit = (state != ST_IDLE) && esp.bus_req;

  // An XRAY request seen in the same cycle as its own ack is the requester's
  // stale level, so it is not taken as a new transaction.
  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      code        <= '0;
      src         <= SRC_BUS;
      done_seen   <= 1'b0;
      xray_ack_q  <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      xray_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (esp.bus_req) begin
            code      <= esp.bus_code;
            src       <= SRC_BUS;
            state     <= ST_REQ;
            cnt       <= REQ_LOAD;
            done_seen <= 1'b0;
          end else if (esp.xray_req && !xray_ack_q) begin
            code      <= ESP_XRAY;
            src       <= SRC_XRAY;
            state     <= ST_REQ;
            cnt       <= REQ_LOAD;
            done_seen <= 1'b0;
          end
        end
        ST_REQ: begin
          if (done_rise) begin
            done_seen <= 1'b1;
          end
          if (cnt == '0) begin
            state <= ST_WAIT_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (done_hit || timeout_hit) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            xray_ack_q <= (src == SRC_XRAY);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (err_clr) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end else begin
        if (timeout_hit) begin
          timeout_err <= 1'b1;
        end
        if (overrun_hit) begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

  assign busy         = (state != ST_IDLE);
  assign esp.esp_req  = (state == ST_REQ);
  assign esp.esp_s    = busy ? code : 3'd0;
  assign esp.wait_o   = busy && (src == SRC_BUS);
  assign esp.xray_ack = xray_ack_q;

endmodule

// File: tb/tb_esp_req_sched.sv
// tb_esp_req_sched: directed testbench for esp_req_sched.
// A transaction-level model predicts all outputs every cycle from request
// and done timestamps; directed sequences add hand-computed literal checks.
module tb_esp_req_sched;
  import esp_pkg::*;

  localparam int RP = 50;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic err_clr = 1'b0;
  logic busy, timeout_err, overrun_err;

  esp_req_sched_if bus_if ();

  esp_req_sched #(
    .REQ_PULSE (RP),
    .TIMEOUT   (TO),
    .CNT_W     (24)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .esp         (bus_if),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state: one open transaction described by its accept edge.
  bit        m_active, m_bus, m_early, m_ack, m_terr, m_oerr;
  logic [2:0] m_code;
  int        m_ts;
  bit [3:0]  pin_hist;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic [2:0] code, input logic xr, input logic clr);
    bus_if.bus_req  = br;
    bus_if.bus_code = code;
    bus_if.xray_req = xr;
    err_clr         = clr;
  endtask

  // The ESP_DONE pin becomes visible to the scheduler three edges after the
  // edge that first samples it high.
  always @(posedge clk) begin
    bit eff, finish, to_hit, was_active, prev_ack;
    cyc++;
    if (srst) begin
      m_active = 0; m_bus = 0; m_early = 0; m_ack = 0;
      m_terr = 0; m_oerr = 0; m_code = 3'd0; m_ts = 0; pin_hist = 4'd0;
    end else begin
      eff        = pin_hist[2] & ~pin_hist[3];
      pin_hist   = {pin_hist[2:0], bus_if.esp_done};
      finish     = 0;
      to_hit     = 0;
      was_active = m_active;
      prev_ack   = m_ack;
      if (m_active) begin
        if (cyc - m_ts <= RP) begin
          if (eff) m_early = 1;
        end else if (eff || m_early) begin
          finish = 1;
        end else if (cyc - m_ts == RP + TO) begin
          finish = 1;
          to_hit = 1;
        end
      end
      m_ack = finish && !m_bus;
      if (finish) m_active = 0;
      if (!was_active) begin
        if (bus_if.bus_req) begin
          m_active = 1; m_bus = 1; m_code = bus_if.bus_code; m_ts = cyc; m_early = 0;
        end else if (bus_if.xray_req && !prev_ack) begin
          m_active = 1; m_bus = 0; m_code = 3'd6; m_ts = cyc; m_early = 0;
        end
      end
      if (err_clr) begin
        m_terr = 0;
        m_oerr = 0;
      end else begin
        if (to_hit) m_terr = 1;
        if (was_active && bus_if.bus_req) m_oerr = 1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [8:0] act, exp;
    if (cyc > 0) begin
      act = {bus_if.esp_req, bus_if.esp_s, bus_if.wait_o, busy, bus_if.xray_ack, timeout_err, overrun_err};
      exp = {m_active && (cyc - m_ts < RP), m_active ? m_code : 3'd0, m_active && m_bus,
             m_active, m_ack, m_terr, m_oerr};
      checkOutput("model_outputs", {23'd0, act}, {23'd0, exp});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected below 200000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, s, acks;
    bus_if.esp_done = 1'b0;
    applyStimulus(0, 3'd0, 0, 0);
    srst = 1'b1;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_esp_req", bus_if.esp_req, 0);
    checkOutput("reset_esp_s", bus_if.esp_s, 0);
    checkOutput("reset_wait", bus_if.wait_o, 0);
    checkOutput("reset_flags", {timeout_err, overrun_err, bus_if.xray_ack}, 0);
    @(negedge clk);

    // Bus transaction with done at cycle 200
    applyStimulus(1, 3'd2, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    s = cyc;
    checkOutput("bus_esp_req", bus_if.esp_req, 1);
    checkOutput("bus_esp_s", bus_if.esp_s, 2);
    checkOutput("bus_wait", bus_if.wait_o, 1);
    n = 0;
    for (int i = 0; i < RP + 10 && bus_if.esp_req; i++) begin
      n++;
      @(negedge clk);
    end
    checkOutput("bus_pulse_len", n, 50);
    while (cyc < s + 200) @(negedge clk);
    bus_if.esp_done = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("bus_wait_before_done", bus_if.wait_o, 1);
    @(negedge clk);
    checkOutput("bus_wait_released", bus_if.wait_o, 0);
    checkOutput("bus_idle_esp_s", bus_if.esp_s, 0);
    checkOutput("bus_idle_busy", busy, 0);
    checkOutput("bus_no_ack", bus_if.xray_ack, 0);
    repeat (4) @(negedge clk);
    bus_if.esp_done = 1'b0;
    repeat (5) @(negedge clk);

    // XRAY transaction
    applyStimulus(0, 3'd0, 1, 0);
    @(negedge clk);
    checkOutput("xray_esp_s", bus_if.esp_s, 6);
    checkOutput("xray_wait", bus_if.wait_o, 0);
    checkOutput("xray_esp_req", bus_if.esp_req, 1);
    repeat (99) @(negedge clk);
    bus_if.esp_done = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.xray_ack) begin
        acks++;
        bus_if.xray_req = 1'b0;
      end
    end
    checkOutput("xray_ack_count", acks, 1);
    checkOutput("xray_no_second", busy, 0);
    bus_if.esp_done = 1'b0;
    repeat (5) @(negedge clk);

    // Done during the REQ pulse
    applyStimulus(1, 3'd3, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    s = cyc;
    repeat (9) @(negedge clk);
    bus_if.esp_done = 1'b1;
    repeat (5) @(negedge clk);
    bus_if.esp_done = 1'b0;
    for (int i = 0; i < 100 && bus_if.esp_req; i++) @(negedge clk);
    checkOutput("early_pulse_len", cyc - s, 50);
    checkOutput("early_wait_done_cycle", busy, 1);
    @(negedge clk);
    checkOutput("early_idle", busy, 0);
    repeat (3) @(negedge clk);

    // Simultaneous bus and XRAY requests
    applyStimulus(1, 3'd5, 1, 0);
    @(negedge clk);
    bus_if.bus_req = 1'b0;
    checkOutput("simul_bus_first_s", bus_if.esp_s, 5);
    checkOutput("simul_bus_wait", bus_if.wait_o, 1);
    repeat (60) @(negedge clk);
    bus_if.esp_done = 1'b1;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checkOutput("simul_bus_done", busy, 0);
    @(negedge clk);
    checkOutput("simul_xray_next_s", bus_if.esp_s, 6);
    checkOutput("simul_xray_wait", bus_if.wait_o, 0);
    bus_if.esp_done = 1'b0;
    repeat (70) @(negedge clk);
    bus_if.esp_done = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.xray_ack) begin
        acks++;
        bus_if.xray_req = 1'b0;
      end
    end
    checkOutput("simul_xray_ack_count", acks, 1);
    bus_if.esp_done = 1'b0;
    repeat (5) @(negedge clk);

    // Watchdog timeout
    applyStimulus(1, 3'd1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    for (int i = 0; i < RP + 10 && bus_if.esp_req; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < TO + 20 && bus_if.wait_o; i++) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_wait_len", n, 1000);
    checkOutput("timeout_err_set", timeout_err, 1);
    repeat (5) @(negedge clk);
    checkOutput("timeout_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("timeout_err_clr", timeout_err, 0);

    // Overrun during WAIT_DONE
    applyStimulus(1, 3'd1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    repeat (79) @(negedge clk);
    applyStimulus(1, 3'd4, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    checkOutput("overrun_set", overrun_err, 1);
    checkOutput("overrun_code_kept", bus_if.esp_s, 1);
    bus_if.esp_done = 1'b1;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checkOutput("overrun_completes", busy, 0);
    checkOutput("overrun_sticky", overrun_err, 1);
    bus_if.esp_done = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("overrun_clr", overrun_err, 0);
    repeat (5) @(negedge clk);

    // err_clr priority, then reset mid-transaction
    applyStimulus(1, 3'd2, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    repeat (59) @(negedge clk);
    applyStimulus(1, 3'd7, 0, 1);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    checkOutput("clr_priority", overrun_err, 0);
    applyStimulus(1, 3'd7, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    checkOutput("overrun_before_reset", overrun_err, 1);
    checkOutput("wait_before_reset", bus_if.wait_o, 1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    checkOutput("midreset_outputs",
                {bus_if.esp_req, bus_if.esp_s, bus_if.wait_o, busy, bus_if.xray_ack, timeout_err, overrun_err}, 0);
    applyStimulus(1, 3'd2, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'd0, 0, 0);
    checkOutput("post_reset_esp_req", bus_if.esp_req, 1);
    checkOutput("post_reset_esp_s", bus_if.esp_s, 2);
    checkOutput("post_reset_wait", bus_if.wait_o, 1);
    repeat (60) @(negedge clk);
    bus_if.esp_done = 1'b1;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checkOutput("post_reset_done", busy, 0);
    bus_if.esp_done = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
